maxpooling1: RTL and testbench

MAXPOOLING1 -- requirements
Module: maxpooling1

---
 rtl/maxpooling1.sv | 145 ++++++++++++++
 tb/tb_maxpooling1.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpooling1.sv
`default_nettype none
// ============================================================================
// Module      : maxpooling1
// Description : 2x2/stride-2 signed max pooling of two 28x28 channels into
//               two 14x14 channels, one output row per cycle, with a
//               ready/acknowledge handshake on both sides.
//               Optional fused ReLU enabled by defining MAXPOOL_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpooling1 #(
    parameter int bitwidth = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [2*28*28*bitwidth-1:0] featuremap1,
    output logic                        reply_to_previous_device,
    output logic [2*14*14*bitwidth-1:0] featuremap2,
    output logic                        finished_for_next_device,
    input  logic                        reply_from_next_device
);

    localparam int IN_W      = 2*28*28*bitwidth;
    localparam int OUT_W     = 2*14*14*bitwidth;
    localparam int IN_IDX_W  = $clog2(IN_W);
    localparam int OUT_IDX_W = $clog2(OUT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        POOL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0]        row_q;
    logic              reply_q;
    logic              finished_q;
    logic [IN_W-1:0]   buf_q;
    logic [OUT_W-1:0]  fmap_q;

    // Pooled value of the current output row, per channel and column.
    logic signed [bitwidth-1:0] pooled_w [0:1][0:13];

    genvar gc, gj;
    generate
        for (gc = 0; gc < 2; gc = gc + 1) begin : g_chan
            for (gj = 0; gj < 14; gj = gj + 1) begin : g_col
                // Window corners: input rows 2r/2r+1, input columns 2j/2j+1.
                // Row index i is the fast-moving one in the flat layout.
                logic [IN_IDX_W-1:0]        lsb00, lsb10, lsb01, lsb11;
                logic signed [bitwidth-1:0] p00, p10, p01, p11;
                logic signed [bitwidth-1:0] max_a, max_b, max_all;

                assign lsb00 = IN_IDX_W'((784*gc + 28*(2*gj)     + 2*int'(row_q))     * bitwidth);
                assign lsb10 = IN_IDX_W'((784*gc + 28*(2*gj)     + 2*int'(row_q) + 1) * bitwidth);
                assign lsb01 = IN_IDX_W'((784*gc + 28*(2*gj + 1) + 2*int'(row_q))     * bitwidth);
                assign lsb11 = IN_IDX_W'((784*gc + 28*(2*gj + 1) + 2*int'(row_q) + 1) * bitwidth);

                assign p00 = buf_q[lsb00 +: bitwidth];
                assign p10 = buf_q[lsb10 +: bitwidth];
                assign p01 = buf_q[lsb01 +: bitwidth];
                assign p11 = buf_q[lsb11 +: bitwidth];

                // Signed tree compare; ties resolve to the (identical) tied value.
                assign max_a   = (p10 > p00) ? p10 : p00;
                assign max_b   = (p11 > p01) ? p11 : p01;
                assign max_all = (max_b > max_a) ? max_b : max_a;

`ifdef MAXPOOL_RELU_EN
                // Fused ReLU: negative maxima are clamped to zero.
                assign pooled_w[gc][gj] = max_all[bitwidth-1] ? '0 : max_all;
`else
                assign pooled_w[gc][gj] = max_all;
`endif
            end
        end
    endgenerate

    // Control FSM: handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            reply_q    <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= READ;
                        reply_q <= 1'b1;
                    end
                end
                READ: begin
                    state_q <= POOL;
                    reply_q <= 1'b0;
                    row_q   <= '0;
                end
                POOL: begin
                    if (row_q == 4'd13) begin
                        state_q    <= DONE;
                        finished_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 4'd1;
                    end
                end
                DONE: begin
                    if (reply_from_next_device) begin
                        state_q    <= IDLE;
                        finished_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    reply_q    <= 1'b0;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: snapshot the input frame in READ, write one pooled row per POOL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q  <= '0;
            fmap_q <= '0;
        end else if (state_q == READ) begin
            buf_q <= featuremap1;
        end else if (state_q == POOL) begin
            for (int c = 0; c < 2; c++) begin
                for (int j = 0; j < 14; j++) begin
                    fmap_q[OUT_IDX_W'((196*c + 14*j + int'(row_q)) * bitwidth) +: bitwidth]
                        <= pooled_w[c][j];
                end
            end
        end
    end

    assign reply_to_previous_device = reply_q;
    assign finished_for_next_device = finished_q;
    assign featuremap2              = fmap_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpooling1.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpooling1
// Description : Self-checking bench for maxpooling1 with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpooling1;

    localparam int BW = 32;
    localparam int IW = 2*28*28*BW;
    localparam int OW = 2*14*14*BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [IW-1:0] featuremap1;
    logic          reply_to_previous_device;
    logic [OW-1:0] featuremap2;
    logic          finished_for_next_device;
    logic          reply_from_next_device;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [OW-1:0] exp_q[$];

    maxpooling1 #(.bitwidth(BW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .featuremap1              (featuremap1),
        .reply_to_previous_device (reply_to_previous_device),
        .featuremap2              (featuremap2),
        .finished_for_next_device (finished_for_next_device),
        .reply_from_next_device   (reply_from_next_device)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] get_in(input logic [IW-1:0] fm, input int c, input int i, input int j);
        return fm[(784*c + 28*j + i)*BW +: BW];
    endfunction

    function automatic logic [IW-1:0] put_in(input logic [IW-1:0] fm, input int c, input int i, input int j,
                                             input logic [31:0] v);
        fm[(784*c + 28*j + i)*BW +: BW] = v;
        return fm;
    endfunction

    function automatic logic [IW-1:0] rand_fm();
        logic [IW-1:0] fm;
        for (int k = 0; k < 1568; k++) fm[k*BW +: BW] = $urandom;
        return fm;
    endfunction

    function automatic logic [IW-1:0] fill_fm(input logic [31:0] v);
        logic [IW-1:0] fm;
        for (int k = 0; k < 1568; k++) fm[k*BW +: BW] = v;
        return fm;
    endfunction

    // Reference pooling model built straight from the element layout formulas.
    function automatic logic [OW-1:0] model(input logic [IW-1:0] fm);
        logic [OW-1:0]      o;
        logic signed [31:0] m, v;
        o = '0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 14; r++)
                for (int j = 0; j < 14; j++) begin
                    m = get_in(fm, c, 2*r, 2*j);
                    v = get_in(fm, c, 2*r+1, 2*j);   if (v > m) m = v;
                    v = get_in(fm, c, 2*r, 2*j+1);   if (v > m) m = v;
                    v = get_in(fm, c, 2*r+1, 2*j+1); if (v > m) m = v;
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    o[(196*c + 14*j + r)*BW +: BW] = m;
                end
        return o;
    endfunction

    function automatic int first_diff(input logic [OW-1:0] a, input logic [OW-1:0] b);
        for (int k = 0; k < 392; k++)
            if (a[k*BW +: BW] !== b[k*BW +: BW]) return k;
        return 0;
    endfunction

    task automatic start_frame(input logic [IW-1:0] fm);
        featuremap1 = fm;
        exp_q.push_back(model(fm));
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (finished_for_next_device !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; reply_from_next_device = 1'b0; featuremap1 = '0;
        tick(); tick();
        n_cmp++;
        if (reply_to_previous_device !== 1'b0) begin
            n_fail++; $display("FAIL reset_reply: got %b expected 0", reply_to_previous_device);
        end
        n_cmp++;
        if (finished_for_next_device !== 1'b0) begin
            n_fail++; $display("FAIL reset_finished: got %b expected 0", finished_for_next_device);
        end
        n_cmp++;
        if (featuremap2 !== '0) begin
            n_fail++; $display("FAIL reset_fmap2: element %0d got %h expected 0",
                               first_diff(featuremap2, '0), featuremap2[first_diff(featuremap2, '0)*BW +: BW]);
        end
        reset = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (reply_to_previous_device !== 1'b0 || finished_for_next_device !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_enable: got reply=%b fin=%b expected 0/0",
                               reply_to_previous_device, finished_for_next_device);
        end
    endtask

    task automatic test_basic();
        logic [IW-1:0] fm;
        logic [OW-1:0] exp;
        int            bad;
        int            k;
        fm = rand_fm();
        fm = put_in(fm, 0, 0, 0, 32'd1);
        fm = put_in(fm, 0, 1, 0, 32'd5);
        fm = put_in(fm, 0, 0, 1, 32'd3);
        fm = put_in(fm, 0, 1, 1, 32'd2);
        start_frame(fm);
        n_cmp++;
        if (reply_to_previous_device !== 1'b1 || finished_for_next_device !== 1'b0) begin
            n_fail++; $display("FAIL basic_cycle1: got reply=%b fin=%b expected 1/0",
                               reply_to_previous_device, finished_for_next_device);
        end
        bad = 0;
        for (int cy = 2; cy <= 15; cy++) begin
            tick();
            if (reply_to_previous_device !== 1'b0 || finished_for_next_device !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL basic_pool_handshake: got %0d bad cycles expected 0", bad);
        end
        tick();
        n_cmp++;
        if (finished_for_next_device !== 1'b1 || reply_to_previous_device !== 1'b0) begin
            n_fail++; $display("FAIL basic_cycle16: got reply=%b fin=%b expected 0/1",
                               reply_to_previous_device, finished_for_next_device);
        end
        n_cmp++;
        if (featuremap2[31:0] !== 32'd5) begin
            n_fail++; $display("FAIL basic_out000: got %h expected 00000005", featuremap2[31:0]);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (featuremap2 !== exp) begin
            k = first_diff(featuremap2, exp);
            n_fail++; $display("FAIL basic_frame: element %0d got %h expected %h",
                               k, featuremap2[k*BW +: BW], exp[k*BW +: BW]);
        end
        reply_from_next_device = 1'b1; tick(); reply_from_next_device = 1'b0;
        n_cmp++;
        if (finished_for_next_device !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack: got fin=%b expected 0", finished_for_next_device);
        end
    endtask

    task automatic test_negative();
        logic [OW-1:0] exp;
        logic [31:0]   want;
        int            cyc;
        int            k;
`ifdef MAXPOOL_RELU_EN
        want = 32'h0000_0000;
`else
        want = 32'hFFFF_FFF9;
`endif
        start_frame(fill_fm(32'hFFFF_FFF9));
        wait_done(1, cyc);
        n_cmp++;
        if (cyc != 16) begin
            n_fail++; $display("FAIL neg_latency: got %0d cycles expected 16", cyc);
        end
        n_cmp++;
        if (featuremap2[391*BW +: BW] !== want) begin
            n_fail++; $display("FAIL neg_last_elem: got %h expected %h", featuremap2[391*BW +: BW], want);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (featuremap2 !== exp) begin
            k = first_diff(featuremap2, exp);
            n_fail++; $display("FAIL neg_frame: element %0d got %h expected %h",
                               k, featuremap2[k*BW +: BW], exp[k*BW +: BW]);
        end
        reply_from_next_device = 1'b1; tick(); reply_from_next_device = 1'b0;
    endtask

    task automatic test_hold();
        logic [OW-1:0] exp;
        int            cyc;
        start_frame(rand_fm());
        wait_done(1, cyc);
        n_cmp++;
        if (cyc != 16) begin
            n_fail++; $display("FAIL hold_latency: got %0d cycles expected 16", cyc);
        end
        exp = exp_q.pop_front();
        for (int n = 0; n < 10; n++) begin
            n_cmp++;
            if (finished_for_next_device !== 1'b1 || featuremap2 !== exp) begin
                n_fail++; $display("FAIL hold_cycle%0d: got fin=%b elem %0d=%h expected fin=1 elem=%h", n,
                                   finished_for_next_device, first_diff(featuremap2, exp),
                                   featuremap2[first_diff(featuremap2, exp)*BW +: BW],
                                   exp[first_diff(featuremap2, exp)*BW +: BW]);
            end
            tick();
        end
        reply_from_next_device = 1'b1; tick(); reply_from_next_device = 1'b0;
        n_cmp++;
        if (finished_for_next_device !== 1'b0 || featuremap2 !== exp) begin
            n_fail++; $display("FAIL hold_ack: got fin=%b same=%b expected fin=0 same=1",
                               finished_for_next_device, featuremap2 === exp);
        end
    endtask

    task automatic test_input_change();
        logic [OW-1:0] exp;
        int            cyc;
        int            k;
        start_frame(rand_fm());
        tick();
        featuremap1 = fill_fm(32'h7FFF_FFFF);
        wait_done(2, cyc);
        n_cmp++;
        if (cyc != 16) begin
            n_fail++; $display("FAIL change_latency: got %0d cycles expected 16", cyc);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (featuremap2 !== exp) begin
            k = first_diff(featuremap2, exp);
            n_fail++; $display("FAIL change_frame: element %0d got %h expected %h",
                               k, featuremap2[k*BW +: BW], exp[k*BW +: BW]);
        end
        reply_from_next_device = 1'b1; tick(); reply_from_next_device = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] exp;
        int            cyc;
        int            k;
        start_frame(rand_fm());
        for (int n = 0; n < 6; n++) tick();
        reset = 1'b1;
        tick();
        void'(exp_q.pop_front());
        n_cmp++;
        if (reply_to_previous_device !== 1'b0 || finished_for_next_device !== 1'b0) begin
            n_fail++; $display("FAIL midreset_handshake: got reply=%b fin=%b expected 0/0",
                               reply_to_previous_device, finished_for_next_device);
        end
        n_cmp++;
        if (featuremap2 !== '0) begin
            n_fail++; $display("FAIL midreset_fmap2: element %0d got %h expected 0",
                               first_diff(featuremap2, '0), featuremap2[first_diff(featuremap2, '0)*BW +: BW]);
        end
        reset = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        n_cmp++;
        if (finished_for_next_device !== 1'b0 || reply_to_previous_device !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: got reply=%b fin=%b expected 0/0",
                               reply_to_previous_device, finished_for_next_device);
        end
        start_frame(rand_fm());
        wait_done(1, cyc);
        n_cmp++;
        if (cyc != 16) begin
            n_fail++; $display("FAIL midreset_latency: got %0d cycles expected 16", cyc);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (featuremap2 !== exp) begin
            k = first_diff(featuremap2, exp);
            n_fail++; $display("FAIL midreset_frame: element %0d got %h expected %h",
                               k, featuremap2[k*BW +: BW], exp[k*BW +: BW]);
        end
        reply_from_next_device = 1'b1; tick(); reply_from_next_device = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp;
        int            pulses;
        int            fins;
        int            last;
        int            k;
        bit            change;
        pulses = 0; fins = 0; last = -1; change = 1'b0;
        featuremap1 = rand_fm();
        enable = 1'b1;
        reply_from_next_device = 1'b1;
        for (int cy = 1; cy <= 80 && fins < 3; cy++) begin
            tick();
            if (change) begin
                featuremap1 = rand_fm();
                change = 1'b0;
            end
            if (reply_to_previous_device === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_cmp++;
                    if (cy - last != 17) begin
                        n_fail++; $display("FAIL b2b_period: got %0d cycles expected 17", cy - last);
                    end
                end
                last = cy;
                exp_q.push_back(model(featuremap1));
                change = 1'b1;
                if (pulses == 3) enable = 1'b0;
            end
            if (finished_for_next_device === 1'b1) begin
                fins++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_frame: got a result expected none");
                end else begin
                    exp = exp_q.pop_front();
                    if (featuremap2 !== exp) begin
                        k = first_diff(featuremap2, exp);
                        n_fail++; $display("FAIL b2b_frame%0d: element %0d got %h expected %h",
                                           fins, k, featuremap2[k*BW +: BW], exp[k*BW +: BW]);
                    end
                end
            end
        end
        enable = 1'b0;
        reply_from_next_device = 1'b0;
        n_cmp++;
        if (pulses != 3 || fins != 3) begin
            n_fail++; $display("FAIL b2b_counts: got pulses=%0d frames=%0d expected 3/3", pulses, fins);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_queue: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_hold();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
